// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for register-register ALU instructions.
// Fetch runs T0-T2 and execute runs T3-T6. Every output is a Moore decode of the state register and IR.
// Build macro MEM_WAIT_EN adds the mem_ready input and holds T1 until memory read data is valid.
module control_sequencer #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [BITS-1:0]      IR,
`ifdef MEM_WAIT_EN
    input  logic                 mem_ready,
`endif
    output logic                 PCout,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 MDRout,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 MDRin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 Read,
    output logic                 IncPC,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 done,
    output logic                 illegal,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Instruction fields
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    assign op = IR[31:27];
    assign ra = IR[26:23];
    assign rb = IR[22:19];
    assign rc = IR[18:15];

    // Low IR bits carry no register-register information
    logic unused_ir;
    assign unused_ir = ^IR[14:0];

    // Opcode decode results; op_strobe bit order is ADD..NOT
    logic [11:0] op_strobe;
    logic        is_alu3;
    logic        is_unary;
    logic        is_muldiv;
    logic        is_legal;

    // GPR select requests from the FSM, expanded to one-hot below
    logic       gpr_drive_en;
    logic [3:0] gpr_drive_idx;
    logic       gpr_load_en;
    logic [3:0] gpr_load_idx;
    logic       strobe_en;

    // Classify the opcode and pick the single ALU strobe it maps to
    always_comb begin
        op_strobe = 12'd0;
        is_alu3   = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        case (op)
            5'b00011: begin op_strobe[0]  = 1'b1; is_alu3   = 1'b1; end
            5'b00100: begin op_strobe[1]  = 1'b1; is_alu3   = 1'b1; end
            5'b00101: begin op_strobe[2]  = 1'b1; is_alu3   = 1'b1; end
            5'b00110: begin op_strobe[3]  = 1'b1; is_alu3   = 1'b1; end
            5'b00111: begin op_strobe[4]  = 1'b1; is_alu3   = 1'b1; end
            5'b01000: begin op_strobe[5]  = 1'b1; is_alu3   = 1'b1; end
            5'b01001: begin op_strobe[6]  = 1'b1; is_alu3   = 1'b1; end
            5'b01010: begin op_strobe[7]  = 1'b1; is_alu3   = 1'b1; end
            5'b01110: begin op_strobe[8]  = 1'b1; is_muldiv = 1'b1; end
            5'b01111: begin op_strobe[9]  = 1'b1; is_muldiv = 1'b1; end
            5'b10000: begin op_strobe[10] = 1'b1; is_unary  = 1'b1; end
            5'b10001: begin op_strobe[11] = 1'b1; is_unary  = 1'b1; end
            default:  ;
        endcase
        is_legal = is_alu3 | is_unary | is_muldiv;
    end

    // State register; reset forces IDLE without waiting for a clock edge
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_next    = state_reg;
        PCout         = 1'b0;
        Zlowout       = 1'b0;
        Zhighout      = 1'b0;
        MDRout        = 1'b0;
        PCin          = 1'b0;
        IRin          = 1'b0;
        RYin          = 1'b0;
        RZin          = 1'b0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        Read          = 1'b0;
        IncPC         = 1'b0;
        done          = 1'b0;
        illegal       = 1'b0;
        strobe_en     = 1'b0;
        gpr_drive_en  = 1'b0;
        gpr_drive_idx = 4'd0;
        gpr_load_en   = 1'b0;
        gpr_load_idx  = 4'd0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_T0;
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                RZin       = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
`ifdef MEM_WAIT_EN
                if (mem_ready) state_next = S_T2;
`else
                state_next = S_T2;
`endif
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (!is_legal) begin
                    illegal    = 1'b1;
                    state_next = run ? S_T0 : S_IDLE;
                end else begin
                    // MUL/DIV take their first operand from Ra, everything else from Rb
                    gpr_drive_en  = 1'b1;
                    gpr_drive_idx = is_muldiv ? ra : rb;
                    RYin          = 1'b1;
                    state_next    = S_T4;
                end
            end
            S_T4: begin
                gpr_drive_en  = 1'b1;
                gpr_drive_idx = is_alu3 ? rc : rb;
                strobe_en     = 1'b1;
                RZin          = 1'b1;
                state_next    = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    state_next = S_T6;
                end else begin
                    gpr_load_en  = 1'b1;
                    gpr_load_idx = ra;
                    done         = 1'b1;
                    state_next   = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                done       = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign {NOT, NEGATE, DIV, MUL, OR, AND, ROL, ROR, SHL, SHR, SUB, ADD} =
        strobe_en ? op_strobe : 12'd0;

    // One-hot expansion; an index with no matching bit leaves the vector all zero
    generate
        for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_gpr_sel
            assign GPRout[gi] = gpr_drive_en && (32'(gpr_drive_idx) == gi);
            assign GPRin[gi]  = gpr_load_en  && (32'(gpr_load_idx)  == gi);
        end
    endgenerate

    assign state = state_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed and random instruction streams against a
// per-instruction expected-trace model. Build with MEM_WAIT_EN defined to exercise T1 stretching.
module tb_control_sequencer;

    localparam int REGS = 16;

    // Bit positions of the single-bit controls inside the packed comparison vector
    localparam int C_PCOUT    = 0;
    localparam int C_ZLOWOUT  = 1;
    localparam int C_ZHIGHOUT = 2;
    localparam int C_MDROUT   = 3;
    localparam int C_PCIN     = 4;
    localparam int C_IRIN     = 5;
    localparam int C_RYIN     = 6;
    localparam int C_RZIN     = 7;
    localparam int C_MARIN    = 8;
    localparam int C_MDRIN    = 9;
    localparam int C_HIIN     = 10;
    localparam int C_LOIN     = 11;
    localparam int C_READ     = 12;
    localparam int C_INCPC    = 13;
    localparam int C_ADD      = 14;
    localparam int C_DONE     = 26;
    localparam int C_ILLEGAL  = 27;

    logic            Clock;
    logic            reset;
    logic            run;
    logic [31:0]     IR;
`ifdef MEM_WAIT_EN
    logic            mem_ready;
`endif
    logic PCout, Zlowout, Zhighout, MDRout;
    logic PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin;
    logic Read, IncPC;
    logic ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT;
    logic [REGS-1:0] GPRin, GPRout;
    logic            done, illegal;
    logic [3:0]      state;

    control_sequencer #(.BITS(32), .REGISTERS(REGS)) dut (
        .Clock(Clock), .reset(reset), .run(run), .IR(IR),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Read(Read), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .AND(AND), .OR(OR), .MUL(MUL), .DIV(DIV), .NEGATE(NEGATE), .NOT(NOT),
        .GPRin(GPRin), .GPRout(GPRout), .done(done), .illegal(illegal), .state(state)
    );

    logic [27:0] dut_ctl;
    assign dut_ctl = {illegal, done, NOT, NEGATE, DIV, MUL, OR, AND, ROL, ROR, SHL, SHR, SUB, ADD,
                      IncPC, Read, LOin, HIin, MDRin, MARin, RZin, RYin, IRin, PCin,
                      MDRout, Zhighout, Zlowout, PCout};

    typedef struct {
        logic [3:0]      st;
        logic [27:0]     ctl;
        logic [REGS-1:0] gin;
        logic [REGS-1:0] gout;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic chk_en = 1'b0;

    // Legal opcodes in ALU-strobe order: 8 three-register ops, MUL, DIV, NEG, NOT
    int legal_ops[12] = '{3, 4, 5, 6, 7, 8, 9, 10, 14, 15, 16, 17};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [REGS-1:0] onehot(input int idx);
        logic [REGS-1:0] v;
        v = '0;
        if (idx < REGS) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic rec_t mk(input int st, input logic [27:0] c,
                                input logic [REGS-1:0] gin, input logic [REGS-1:0] gout);
        rec_t r;
        r.st = 4'(st); r.ctl = c; r.gin = gin; r.gout = gout;
        return r;
    endfunction

    // Append the full expected trace of one instruction; returns its length in cycles
    function automatic int push_instr(input logic [31:0] ir, input int waits);
        int op, ra, rb, rc, k, n;
        logic muldiv, alu3;
        logic [27:0] c;
        op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        k = -1;
        for (int i = 0; i < 12; i++) if (legal_ops[i] == op) k = i;
        c = '0; c[C_PCOUT] = 1; c[C_MARIN] = 1; c[C_INCPC] = 1; c[C_RZIN] = 1;
        exp_q.push_back(mk(1, c, '0, '0));
        for (int w = 0; w <= waits; w++) begin
            c = '0; c[C_ZLOWOUT] = 1; c[C_PCIN] = 1; c[C_READ] = 1; c[C_MDRIN] = 1;
            exp_q.push_back(mk(2, c, '0, '0));
        end
        c = '0; c[C_MDROUT] = 1; c[C_IRIN] = 1;
        exp_q.push_back(mk(3, c, '0, '0));
        n = 3 + waits;
        if (k < 0) begin
            c = '0; c[C_ILLEGAL] = 1;
            exp_q.push_back(mk(4, c, '0, '0));
            return n + 1;
        end
        muldiv = (k == 8 || k == 9);
        alu3   = (k < 8);
        c = '0; c[C_RYIN] = 1;
        exp_q.push_back(mk(4, c, '0, onehot(muldiv ? ra : rb)));
        c = '0; c[C_ADD + k] = 1; c[C_RZIN] = 1;
        exp_q.push_back(mk(5, c, '0, onehot(alu3 ? rc : rb)));
        if (muldiv) begin
            c = '0; c[C_ZLOWOUT] = 1; c[C_LOIN] = 1;
            exp_q.push_back(mk(6, c, '0, '0));
            c = '0; c[C_ZHIGHOUT] = 1; c[C_HIIN] = 1; c[C_DONE] = 1;
            exp_q.push_back(mk(7, c, '0, '0));
            return n + 4;
        end
        c = '0; c[C_ZLOWOUT] = 1; c[C_DONE] = 1;
        exp_q.push_back(mk(6, c, onehot(ra), '0));
        return n + 3;
    endfunction

    // Compare DUT against the front of the expected trace every cycle
    always @(negedge Clock) begin : cmp
        rec_t r;
        if (chk_en) begin
            cyc++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trace_underflow@%0d: got state %0h expected no cycle", cyc, state);
            end else begin
                r = exp_q.pop_front();
                chk($sformatf("state@%0d", cyc), state, r.st);
                chk($sformatf("ctl@%0d", cyc), dut_ctl, r.ctl);
                chk($sformatf("GPRin@%0d", cyc), GPRin, r.gin);
                chk($sformatf("GPRout@%0d", cyc), GPRout, r.gout);
            end
        end
    end

    // Hand-computed spot checks for the directed instructions (no memory wait)
    task automatic lit_checks(input int mode, input int j);
        case (mode)
            1: case (j)
                3: begin chk("and_t3_gprout", GPRout, 16'h0004); chk("and_t3_ryin", RYin, 1); end
                4: begin chk("and_t4_gprout", GPRout, 16'h0010); chk("and_t4_and", AND, 1);
                         chk("and_t4_rzin", RZin, 1); end
                5: begin chk("and_t5_gprin", GPRin, 16'h0020); chk("and_t5_done", done, 1);
                         chk("and_t5_zlowout", Zlowout, 1); end
                default: ;
            endcase
            2: case (j)
                3: chk("mul_t3_gprout", GPRout, 16'h0004);
                4: begin chk("mul_t4_gprout", GPRout, 16'h0010); chk("mul_t4_mul", MUL, 1); end
                5: begin chk("mul_t5_loin", LOin, 1); chk("mul_t5_done", done, 0); end
                6: begin chk("mul_t6_hiin", HIin, 1); chk("mul_t6_zhighout", Zhighout, 1);
                         chk("mul_t6_done", done, 1); end
                default: ;
            endcase
            3: case (j)
                4: begin chk("neg_t4_gprout", GPRout, 16'h0004); chk("neg_t4_negate", NEGATE, 1); end
                5: begin chk("neg_t5_gprin", GPRin, 16'h0002); chk("neg_t5_done", done, 1); end
                default: ;
            endcase
            4: case (j)
                3: begin chk("ill_t3_state", state, 4); chk("ill_t3_illegal", illegal, 1);
                         chk("ill_t3_gprout", GPRout, 0); end
                default: ;
            endcase
            default: ;
        endcase
    endtask

    // Idle cycle: called just after a rising edge that left the DUT in IDLE
    task automatic idle_cycle();
        exp_q.push_back(mk(0, '0, '0, '0));
        run = 1'b0;
`ifdef MEM_WAIT_EN
        mem_ready = 1'($urandom);
`endif
        @(posedge Clock); #1;
    endtask

    // From IDLE, raise run so the next edge enters T0
    task automatic start_batch();
        exp_q.push_back(mk(0, '0, '0, '0));
        run = 1'b1;
        @(posedge Clock); #1;
    endtask

    // Run one instruction starting in T0; run is random except in the final execute state
    task automatic exec_one(input logic [31:0] ir, input int waits, input int mode, input logic keep_run);
        int len;
        len = push_instr(ir, waits);
        IR  = ir;
        $display("instr %08h op=%02h waits=%0d cycles=%0d keep_run=%0b", ir, ir[31:27], waits, len, keep_run);
        for (int j = 0; j < len; j++) begin
            if (j == len - 1) run = keep_run;
            else              run = 1'($urandom);
`ifdef MEM_WAIT_EN
            if (j >= 1 && j <= waits)  mem_ready = 1'b0;
            else if (j == waits + 1)   mem_ready = 1'b1;
            else                       mem_ready = 1'($urandom);
`endif
            lit_checks(mode, j);
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        int n, dir_wait, w;
        logic [31:0] ir;
        reset = 1'b0; run = 1'b0; IR = 32'h0;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b0;
        dir_wait  = 3;
`else
        dir_wait  = 0;
`endif
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_hold_state", state, 0);
        chk("rst_hold_ctl", dut_ctl, 0);
        reset = 1'b1;
        @(posedge Clock); #1;
        chk("rst_rel_state", state, 0);
        chk("rst_rel_ctl", dut_ctl, 0);
        chk("rst_rel_gpr", {GPRin, GPRout}, 0);
        chk_en = 1'b1;

        // Directed: AND, MUL, NEG, illegal, then two back-to-back ADDs
        start_batch();
        exec_one(32'h4A920000, 0, 1, 1'b1);
        exec_one(32'h71200000, 0, 2, 1'b1);
        exec_one(32'h80900000, 0, 3, 1'b1);
        exec_one(32'hF8000000, 0, 4, 1'b1);
        exec_one(32'h18A10000, dir_wait, 0, 1'b1);
        exec_one(32'h19320000, 0, 0, 1'b0);
        idle_cycle();
        idle_cycle();

        // Random batches of instructions separated by idle gaps
        for (int b = 0; b < 40; b++) begin
            start_batch();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                ir = $urandom;
                if ($urandom_range(0, 4) != 0) ir[31:27] = 5'(legal_ops[$urandom_range(0, 11)]);
`ifdef MEM_WAIT_EN
                w = $urandom_range(0, 3);
`else
                w = 0;
`endif
                exec_one(ir, w, 0, (i < n - 1));
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        chk_en = 1'b0;
        chk("trace_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of T4
        IR  = 32'h18A10000;
        run = 1'b1;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (5) @(posedge Clock);
        #1;
        chk("pre_rst_state_t4", state, 5);
        reset = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_ctl", dut_ctl, 0);
        chk("async_rst_gpr", {GPRin, GPRout}, 0);
        #2;
        reset = 1'b1;
        @(posedge Clock); #1;
        chk("post_rst_t0", state, 1);
        run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

endmodule
